led_button_ctrl: RTL
====================

# led_button_ctrl

Controller that sequences the board's two user LEDs from its two push buttons. Each raw button input is synchronised, debounced and edge-detected. Each press advances the paired LED through a four-mode cycle: OFF, ON, slow blink, fast blink. It sits directly between the top-level `btn1`/`btn2` pins and the `led1`/`led2` pins, and replaces ad-hoc glue logic in the top level.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required to accept a new button level (10 ms at 25 MHz); minimum 2.
- `SLOW_HALF`, default 12500000: cycles per half-period of slow blink; minimum 1.
- `FAST_HALF`, default 3125000: cycles per half-period of fast blink; minimum 1.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn1`  in  1  raw button 1, asynchronous, 1 = pressed.
- `btn2`  in  1  raw button 2, asynchronous, 1 = pressed.
- `led1`  out  1  LED 1 drive, registered, 1 = lit.
- `led2`  out  1  LED 2 drive, registered, 1 = lit.
- `led1_mode`  out  2  current mode of LED 1.
- `led2_mode`  out  2  current mode of LED 2.

## Operation
- Mode encoding: 0 OFF, 1 ON, 2 BLINK_SLOW, 3 BLINK_FAST.
- Synchroniser: two flops per button (`s1`, then `s2`).
- Debouncer, per button:
  - State is a debounced level `db` and a counter `cnt`.
  - If `s2 == db`, `cnt` is set to 0.
  - Otherwise `cnt` increments. When `cnt == DEBOUNCE_CYCLES-1` and `s2 != db` still holds, `db <= s2` and `cnt <= 0`.
  - Any return to `db` before then discards the candidate level.
- Press detect: registered one-cycle pulse `press` on a 0→1 transition of `db`. Releases (1→0) generate nothing.
- Mode FSM, per LED, two-bit state:
  - On its own `press`: mode advances 0→1→2→3→0 (wraps).
  - Simultaneous press, where `press1` and `press2` are high in the same cycle: both modes go to OFF, regardless of current mode. This is the all-off gesture.
- Blink phases:
  - Two free-running phase generators shared by both LEDs.
  - Slow: counter 0..SLOW_HALF-1; `ph_slow` toggles on wrap.
  - Fast: same structure using FAST_HALF and `ph_fast`.
  - Phases are never restarted on mode change.
- Output register: `ledN <= (mode==1) | (mode==2 & ph_slow) | (mode==3 & ph_fast)`.
- `ledN_mode` is driven directly from the mode register.
- Counter widths: `$clog2` of the respective parameter, minimum 1 bit. No overflow is possible by construction.

## Timing
- Reset: while `rst_n` = 0, all state and outputs are 0 asynchronously.
  - Outputs: `led1` = `led2` = 0, `led1_mode` = `led2_mode` = 0.
  - Internal: `db` = 0, `cnt` = 0, `s1` = `s2` = 0, phase counters = 0, phases = 0.
  - Reset asserted mid-debounce or mid-blink discards all progress.
- Reset release: outputs change no earlier than the first rising edge after `rst_n` rises.
- Press latency, with edge 1 as the first edge sampling the new raw level:
  - `s2` updates at edge 2.
  - `db` updates at edge 2+DEBOUNCE_CYCLES.
  - `press` is high for the cycle after edge 3+DEBOUNCE_CYCLES.
  - `ledN_mode` updates at edge 4+DEBOUNCE_CYCLES.
  - `ledN` reflects the new mode at edge 5+DEBOUNCE_CYCLES.
- Glitch rejection: any excursion with `s2` different for fewer than DEBOUNCE_CYCLES consecutive cycles produces no `press`.
- Holding: a held button produces exactly one `press`. The next press requires a debounced release followed by a debounced press.
- Blink period:
  - Slow: `ph_slow` toggles every SLOW_HALF cycles, first at edge SLOW_HALF after reset release; period 2·SLOW_HALF.
  - Fast: same rule using FAST_HALF.
- Presses whose `press` pulses fall in cycles one or more apart are processed independently. The pair counts as simultaneous only when both pulses share the same cycle.

## Test plan
Use DEBOUNCE_CYCLES=4, SLOW_HALF=8, FAST_HALF=2 for all scenarios.
- Reset: assert `rst_n`=0 while both buttons are held high. Required: all outputs 0. Release reset and hold the buttons for 3 cycles. Required: modes still 0, no `press`.
- Single press: `btn1` high for 20 cycles from edge 1, then low. Required: `led1_mode`=1 at edge 8, `led1`=1 at edge 9, `led2` stays 0. Further presses step 1→2→3→0, with `led1` toggling every 8 cycles in mode 2 and every 2 cycles in mode 3.
- Glitch: `btn2` pulses of 1, 2 and 3 cycles separated by 10 low cycles. Required: `led2_mode` stays 0.
- Bounce: `btn1` sequence 1,0,1,1,0 then held 1. Required: exactly one increment, occurring DEBOUNCE_CYCLES+3 edges after the final rising edge of the sequence.
- Simultaneous: set `led1_mode`=2 and `led2_mode`=3, then raise both buttons on the same edge. Required: both modes 0 at the same edge, both LEDs 0 one edge later.
- Reset mid-operation: with `btn1` held, assert `rst_n` for 1 cycle at cnt=2. Required: immediate all-zero outputs, and counting restarts from 0 after release.

Source files
------------

// File: rtl/led_button_ctrl_if.sv
// Pin-level bundle between the board buttons/LEDs and the LED controller.
interface led_button_ctrl_if;
    logic       btn1;
    logic       btn2;
    logic       led1;
    logic       led2;
    logic [1:0] led1_mode;
    logic [1:0] led2_mode;

    // Drives the buttons, observes the LEDs (board side / testbench).
    modport master (
        output btn1,
        output btn2,
        input  led1,
        input  led2,
        input  led1_mode,
        input  led2_mode
    );

    // The controller itself.
    modport slave (
        input  btn1,
        input  btn2,
        output led1,
        output led2,
        output led1_mode,
        output led2_mode
    );
endinterface

// File: rtl/led_button_ctrl.sv
// Two-button / two-LED controller: each button is synchronised, debounced and
// edge-detected; every press steps its LED through OFF, ON, slow blink, fast
// blink. Pressing both buttons in the same cycle turns both LEDs off.
module led_button_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned SLOW_HALF       = 12500000,
    parameter int unsigned FAST_HALF       = 3125000
) (
    input  logic              clk,
    input  logic              rst_n,
    led_button_ctrl_if.slave  pins_io
);

    localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SlowW = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;
    localparam int unsigned FastW = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;

    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SlowW-1:0] SlowLast = SlowW'(SLOW_HALF - 1);
    localparam logic [FastW-1:0] FastLast = FastW'(FAST_HALF - 1);

    typedef enum logic [1:0] {
        ModeOff  = 2'd0,
        ModeOn   = 2'd1,
        ModeSlow = 2'd2,
        ModeFast = 2'd3
    } mode_e;

    // Index 0 is button/LED 1, index 1 is button/LED 2.
    logic [1:0]     btn_raw;
    logic [1:0]     s1_q, s2_q;
    logic [1:0]     db_q, db_d;
    logic [1:0]     db_prev_q;
    logic [1:0]     press_q;
    logic [DbW-1:0] cnt_q [2];
    logic [DbW-1:0] cnt_d [2];

    mode_e          mode_q [2];
    mode_e          mode_d [2];
    logic [1:0]     led_q, led_d;

    logic [SlowW-1:0] slow_cnt_q;
    logic [FastW-1:0] fast_cnt_q;
    logic             ph_slow_q, ph_fast_q;

    assign btn_raw = {pins_io.btn2, pins_io.btn1};

    // Two-flop synchroniser for the asynchronous button pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn_raw;
            s2_q <= s1_q;
        end
    end

    // Debounce: accept a new level only after it differs from db for DEBOUNCE_CYCLES cycles.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_d[i]  = db_q[i];
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DbLast) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state and registered rising-edge press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q      <= '0;
            db_prev_q <= '0;
            press_q   <= '0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
        end else begin
            db_q      <= db_d;
            db_prev_q <= db_q;
            press_q   <= db_q & ~db_prev_q;
            cnt_q[0]  <= cnt_d[0];
            cnt_q[1]  <= cnt_d[1];
        end
    end

    // Free-running blink phase generators; never restarted by mode changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slow_cnt_q <= '0;
            fast_cnt_q <= '0;
            ph_slow_q  <= 1'b0;
            ph_fast_q  <= 1'b0;
        end else begin
            if (slow_cnt_q == SlowLast) begin
                slow_cnt_q <= '0;
                ph_slow_q  <= ~ph_slow_q;
            end else begin
                slow_cnt_q <= slow_cnt_q + 1'b1;
            end
            if (fast_cnt_q == FastLast) begin
                fast_cnt_q <= '0;
                ph_fast_q  <= ~ph_fast_q;
            end else begin
                fast_cnt_q <= fast_cnt_q + 1'b1;
            end
        end
    end

    // Mode FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q[0] <= ModeOff;
            mode_q[1] <= ModeOff;
        end else begin
            mode_q[0] <= mode_d[0];
            mode_q[1] <= mode_d[1];
        end
    end

    // Mode FSM next state: own press steps the cycle, a shared-cycle press clears both.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mode_d[i] = mode_q[i];
            if (&press_q) begin
                mode_d[i] = ModeOff;
            end else if (press_q[i]) begin
                unique case (mode_q[i])
                    ModeOff:  mode_d[i] = ModeOn;
                    ModeOn:   mode_d[i] = ModeSlow;
                    ModeSlow: mode_d[i] = ModeFast;
                    ModeFast: mode_d[i] = ModeOff;
                    default:  mode_d[i] = ModeOff;
                endcase
            end
        end
    end

    // Mode FSM output decode: LED level from mode and blink phase.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            led_d[i] = 1'b0;
            unique case (mode_q[i])
                ModeOff:  led_d[i] = 1'b0;
                ModeOn:   led_d[i] = 1'b1;
                ModeSlow: led_d[i] = ph_slow_q;
                ModeFast: led_d[i] = ph_fast_q;
                default:  led_d[i] = 1'b0;
            endcase
        end
    end

    // Registered LED drive so the pins are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign pins_io.led1      = led_q[0];
    assign pins_io.led2      = led_q[1];
    assign pins_io.led1_mode = mode_q[0];
    assign pins_io.led2_mode = mode_q[1];

endmodule
